// File: rtl/rvc_asap_5pl_vga_ctrl.sv
// VGA timing generator and 1-bpp framebuffer scanner for the rvc_asap 5-stage core.
// Prefetches one 32-pixel word ahead of the beam and drives registered 4:4:4 RGB and syncs.
module rvc_asap_5pl_vga_ctrl #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic        clock,
    input  logic        rst,
    output logic [13:0] address_b,
    input  logic [31:0] q_b,
    input  logic        vga_en,
    input  logic [11:0] fg_color,
    input  logic [11:0] bg_color,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        h_sync,
    output logic        v_sync
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int WPL     = H_VISIBLE / 32;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_PRE    = HW'(H_TOTAL - 2);
    localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_MIDLIM = HW'(H_VISIBLE - 2);
    localparam logic [HW-1:0] HS_START = HW'(H_VISIBLE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FP + H_SYNC - 1);

    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_VIS_M1 = VW'(V_VISIBLE - 1);
    localparam logic [VW-1:0] VS_START = VW'(V_VISIBLE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FP + V_SYNC - 1);

    localparam logic [13:0] WPL14 = 14'(WPL);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [13:0]   line_base;
    logic [31:0]   pix_sr;
    logic          fetch;
    logic          fetch_d;
    logic          visible;
    logic [11:0]   pix_color;

    // Word 0 of the next line is fetched two cycles before the wrap; the rest
    // of the line is fetched two cycles before each 32-pixel boundary.
    always_comb begin
        fetch     = 1'b0;
        address_b = '0;
        if (h_cnt == H_PRE && (v_cnt == V_LAST || v_cnt < V_VIS_M1)) begin
            fetch     = 1'b1;
            address_b = (v_cnt == V_LAST) ? 14'd0 : line_base + WPL14;
        end else if (v_cnt < V_VIS && h_cnt[4:0] == 5'd30 && h_cnt < H_MIDLIM) begin
            fetch     = 1'b1;
            address_b = line_base + 14'(h_cnt[HW-1:5]) + 14'd1;
        end
    end

    always_comb begin
        visible   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        pix_color = '0;
        if (visible && vga_en)
            pix_color = pix_sr[h_cnt[4:0]] ? fg_color : bg_color;
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            h_cnt     <= H_PRE;
            v_cnt     <= V_LAST;
            line_base <= '0;
            pix_sr    <= '0;
            fetch_d   <= 1'b0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            h_sync    <= 1'b1;
            v_sync    <= 1'b1;
        end else begin
            fetch_d <= fetch;
            if (fetch_d)
                pix_sr <= q_b;

            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt     <= '0;
                    line_base <= '0;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                    if (v_cnt < V_VIS)
                        line_base <= line_base + WPL14;
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end

            {red, green, blue} <= pix_color;
            h_sync <= !(h_cnt >= HS_START && h_cnt <= HS_END);
            v_sync <= !(v_cnt >= VS_START && v_cnt <= VS_END);
        end
    end

endmodule

// File: tb/tb_rvc_asap_5pl_vga_ctrl.sv
// Bench for rvc_asap_5pl_vga_ctrl on a reduced raster so whole frames fit in a short run.
// A frame-position model derives address, sync and colour for every cycle.
module tb_rvc_asap_5pl_vga_ctrl;

    localparam int H_VISIBLE = 96;
    localparam int H_FP      = 8;
    localparam int H_SYNC    = 12;
    localparam int H_BP      = 8;
    localparam int V_VISIBLE = 6;
    localparam int V_FP      = 2;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 3;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int FRAME     = H_TOTAL * V_TOTAL;
    localparam int WPL       = H_VISIBLE / 32;

    logic        clock = 1'b0;
    logic        rst   = 1'b1;
    logic [13:0] address_b;
    logic [31:0] q_b;
    logic        vga_en;
    logic [11:0] fg_color;
    logic [11:0] bg_color;
    logic [3:0]  red, green, blue;
    logic        h_sync, v_sync;

    logic [31:0] mem [0:16383];

    int          t;
    int          n_checks;
    int          n_pass;
    int          n_fail;
    logic [11:0] exp_rgb;
    logic        exp_hs;
    logic        exp_vs;

    rvc_asap_5pl_vga_ctrl #(
        .H_VISIBLE(H_VISIBLE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VISIBLE(V_VISIBLE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clock(clock),
        .rst(rst),
        .address_b(address_b),
        .q_b(q_b),
        .vga_en(vga_en),
        .fg_color(fg_color),
        .bg_color(bg_color),
        .red(red),
        .green(green),
        .blue(blue),
        .h_sync(h_sync),
        .v_sync(v_sync)
    );

    always #5 clock = ~clock;

    always @(posedge clock) q_b <= mem[address_b];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, expv, t);
        end
    endtask

    // Cycle 0 after reset release sits at the second-to-last pixel of the last line.
    function automatic void pos_of(input int tt, output int h, output int v);
        int p;
        p = (tt + (V_TOTAL - 1) * H_TOTAL + H_TOTAL - 2) % FRAME;
        h = p % H_TOTAL;
        v = p / H_TOTAL;
    endfunction

    function automatic int exp_addr(input int h, input int v);
        int line;
        if (h == H_TOTAL - 2) begin
            line = (v == V_TOTAL - 1) ? 0 : v + 1;
            return (line < V_VISIBLE) ? line * WPL : 0;
        end
        if (v < V_VISIBLE && (h + 2) % 32 == 0 && (h + 2) / 32 >= 1 && (h + 2) / 32 < WPL)
            return v * WPL + (h + 2) / 32;
        return 0;
    endfunction

    function automatic logic [11:0] exp_color(input int h, input int v);
        logic [31:0] w;
        if (h >= H_VISIBLE || v >= V_VISIBLE || !vga_en)
            return 12'h000;
        w = mem[v * WPL + h / 32];
        return w[h % 32] ? fg_color : bg_color;
    endfunction

    // One clock cycle: check this cycle's address and the outputs produced by
    // the previous cycle, then predict the outputs for the next one.
    task automatic step();
        int h, v;
        int a;
        @(negedge clock);
        h = 0;
        v = 0;
        a = 0;
        if (!rst) begin
            pos_of(t, h, v);
            a = exp_addr(h, v);
        end
        chk("addr", 32'(address_b), a);
        chk("rgb", 32'({red, green, blue}), 32'(exp_rgb));
        chk("hsync", 32'(h_sync), 32'(exp_hs));
        chk("vsync", 32'(v_sync), 32'(exp_vs));
        if (rst) begin
            exp_rgb = 12'h000;
            exp_hs  = 1'b1;
            exp_vs  = 1'b1;
        end else begin
            exp_rgb = exp_color(h, v);
            exp_hs  = !(h >= H_VISIBLE + H_FP && h < H_VISIBLE + H_FP + H_SYNC);
            exp_vs  = !(v >= V_VISIBLE + V_FP && v < V_VISIBLE + V_FP + V_SYNC);
        end
        @(posedge clock);
        #1;
        if (!rst) t++;
    endtask

    task automatic run_to(input int n);
        while (t < n) step();
    endtask

    task automatic goto_pos(input int h0, input int v0);
        int h, v, g;
        g = 0;
        pos_of(t, h, v);
        while (!(h == h0 && v == v0) && g < 2 * FRAME) begin
            step();
            g++;
            pos_of(t, h, v);
        end
        chk("goto_bound", 32'(g < 2 * FRAME), 32'd1);
    endtask

    initial begin
        int hlow, vlow, nz;
        logic [31:0] w;
        t        = 0;
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        exp_rgb  = 12'h000;
        exp_hs   = 1'b1;
        exp_vs   = 1'b1;
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        mem[0]       = 32'h0000_0001;
        mem[WPL - 1] = 32'h8000_0000;
        fg_color = 12'hFFF;
        bg_color = 12'h00F;
        vga_en   = 1'b1;

        // Reset values, then pixel mapping at the line-0 boundaries
        @(posedge clock);
        #1;
        repeat (3) step();
        rst = 1'b0;
        t   = 0;
        run_to(3);
        chk("pix_first", 32'({red, green, blue}), 32'h FFF);
        run_to(4);
        chk("pix_second", 32'({red, green, blue}), 32'h00F);
        run_to(H_VISIBLE + 2);
        chk("pix_last", 32'({red, green, blue}), 32'hFFF);
        run_to(H_VISIBLE + 3);
        chk("pix_blank", 32'({red, green, blue}), 32'h000);
        run_to(H_VISIBLE + H_FP + 2);
        chk("hs_before", 32'(h_sync), 32'd1);
        run_to(H_VISIBLE + H_FP + 3);
        chk("hs_first_low", 32'(h_sync), 32'd0);
        run_to(FRAME + 10);

        hlow = 0;
        vlow = 0;
        for (int k = 0; k < FRAME; k++) begin
            step();
            if (!h_sync) hlow++;
            if (!v_sync) vlow++;
        end
        chk("hs_low_per_frame", hlow, H_SYNC * V_TOTAL);
        chk("vs_low_per_frame", vlow, V_SYNC * H_TOTAL);

        // Random framebuffer with an all-ones line 1 for the colour switch
        rst = 1'b1;
        #1;
        exp_rgb = 12'h000;
        exp_hs  = 1'b1;
        exp_vs  = 1'b1;
        repeat (2) step();
        for (int i = 0; i < V_VISIBLE * WPL; i++) mem[i] = $urandom;
        for (int i = WPL; i < 2 * WPL; i++) mem[i] = 32'hFFFF_FFFF;
        fg_color = 12'hF00;
        bg_color = 12'($urandom);
        rst = 1'b0;
        t   = 0;
        goto_pos(40, 1);
        chk("fg_before_switch", 32'({red, green, blue}), 32'hF00);
        fg_color = 12'h0F0;
        step();
        chk("fg_after_switch", 32'({red, green, blue}), 32'h0F0);

        for (int k = 0; k < 2 * FRAME; k++) begin
            if ($urandom_range(0, 40) == 0) vga_en = ~vga_en;
            if ($urandom_range(0, 60) == 0) fg_color = 12'($urandom);
            if ($urandom_range(0, 60) == 0) bg_color = 12'($urandom);
            step();
        end

        // Display disabled for a whole frame, then re-enabled mid-line
        vga_en = 1'b0;
        step();
        nz   = 0;
        hlow = 0;
        for (int k = 0; k < FRAME; k++) begin
            step();
            if ({red, green, blue} != 12'h000) nz++;
            if (!h_sync) hlow++;
        end
        chk("disabled_black", nz, 0);
        chk("disabled_hs_low", hlow, H_SYNC * V_TOTAL);
        fg_color = 12'hABC;
        bg_color = 12'h123;
        goto_pos(10, 2);
        vga_en = 1'b1;
        step();
        w = mem[2 * WPL];
        chk("reenable", 32'({red, green, blue}), w[10] ? 32'hABC : 32'h123);

        // Asynchronous reset in the middle of a visible line
        goto_pos(50, V_VISIBLE / 2);
        rst = 1'b1;
        #1;
        chk("midrst_rgb", 32'({red, green, blue}), 32'h000);
        chk("midrst_hs", 32'(h_sync), 32'd1);
        chk("midrst_vs", 32'(v_sync), 32'd1);
        chk("midrst_addr", 32'(address_b), 32'd0);
        exp_rgb = 12'h000;
        exp_hs  = 1'b1;
        exp_vs  = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        t   = 0;
        run_to(3);
        w = mem[0];
        chk("midrst_pix0", 32'({red, green, blue}), w[0] ? 32'(fg_color) : 32'(bg_color));
        run_to(H_VISIBLE + H_FP + 2);
        chk("midrst_hs_before", 32'(h_sync), 32'd1);
        run_to(H_VISIBLE + H_FP + 3);
        chk("midrst_hs_low", 32'(h_sync), 32'd0);
        run_to(FRAME + H_TOTAL);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
